router_rx_client: RTL and testbench

ROUTER_RX_CLIENT -- requirements
Module: router_rx_client

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_parity_acc.sv | 22 ++
 rtl/router_rx_client.sv | 136 +++++++++++++
 tb/tb_router_rx_client.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state encoding and header layout for the router rx client
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_HDR_RD,
    ST_HDR_CAP,
    ST_PAYLOAD,
    ST_PAR_RD,
    ST_PAR_CAP,
    ST_CHECK
  } rx_state_t;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_W   = 2;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_W    = 6;
  localparam int MAX_LEN      = 63;
  localparam int TIMEOUT      = 30;

endpackage

// File: rtl/router_parity_acc.sv
// rtl/router_parity_acc.sv - running XOR of bytes seen in one packet
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] parity
);

  // clear wins over enable so a new packet always starts from zero
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      parity <= '0;
    end else if (enable) begin
      parity <= parity ^ din;
    end
  end

endmodule

// File: rtl/router_rx_client.sv
// rtl/router_rx_client.sv - drains one router output port and streams packet payload downstream
module router_rx_client
  import router_pkg::*;
#(
  parameter int START_DELAY = 2,
  parameter int DATA_W      = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  vld_out,
  input  logic [DATA_W-1:0]     data_out,
  input  logic                  soft_reset,
  input  logic                  rx_ready,
  output logic                  read_en,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  output logic [HDR_ADDR_W-1:0] pkt_addr,
  output logic [HDR_LEN_W-1:0]  pkt_len,
  output logic                  pkt_done,
  output logic                  parity_err,
  output logic                  pkt_abort,
  output logic                  busy
);

  // DELAY lasts START_DELAY cycles: the counter runs 0 .. START_DELAY-1
  localparam logic [4:0] DELAY_LAST = (START_DELAY > 0) ? 5'(START_DELAY - 1) : 5'd0;

  rx_state_t             state;
  logic [4:0]            delay_cnt;
  logic [HDR_LEN_W-1:0]  issue_cnt;
  logic                  rx_valid_q;
  logic [DATA_W-1:0]     run_parity;

  // read strobe from registered state: header/parity need data only, payload also needs downstream space
  always_comb begin
    read_en = 1'b0;
    case (state)
      ST_HDR_RD,
      ST_PAR_RD:  read_en = vld_out;
      ST_PAYLOAD: read_en = vld_out & rx_ready;
      default:    read_en = 1'b0;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign rx_valid = rx_valid_q;
  // router data is valid the cycle after the read, which is exactly the cycle rx_valid is up
  assign rx_data  = rx_valid_q ? data_out : '0;

  // header and every delivered payload byte fold into the running parity
  router_parity_acc #(
    .DATA_W (DATA_W)
  ) u_parity (
    .clock  (clock),
    .resetn (resetn),
    .clear  (state == ST_IDLE),
    .enable ((state == ST_HDR_CAP) | rx_valid_q),
    .din    (data_out),
    .parity (run_parity)
  );

  // packet sequencing FSM with registered header fields and one-cycle status pulses
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      delay_cnt  <= '0;
      issue_cnt  <= '0;
      rx_valid_q <= 1'b0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
      rx_valid_q <= 1'b0;
      if (soft_reset && (state != ST_IDLE)) begin
        // flush: abandon the packet and drop any byte whose read was issued this cycle
        state     <= ST_IDLE;
        pkt_abort <= 1'b1;
        delay_cnt <= '0;
        issue_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (vld_out) begin
              delay_cnt <= '0;
              state     <= (START_DELAY == 0) ? ST_HDR_RD : ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (delay_cnt == DELAY_LAST) begin
              state <= ST_HDR_RD;
            end else begin
              delay_cnt <= delay_cnt + 5'd1;
            end
          end
          ST_HDR_RD: begin
            if (read_en) state <= ST_HDR_CAP;
          end
          ST_HDR_CAP: begin
            pkt_addr  <= data_out[HDR_ADDR_LSB +: HDR_ADDR_W];
            pkt_len   <= data_out[HDR_LEN_LSB +: HDR_LEN_W];
            issue_cnt <= '0;
            state     <= (data_out[HDR_LEN_LSB +: HDR_LEN_W] != '0) ? ST_PAYLOAD : ST_PAR_RD;
          end
          ST_PAYLOAD: begin
            if (read_en) begin
              rx_valid_q <= 1'b1;
              if (issue_cnt == pkt_len - 6'd1) begin
                state <= ST_PAR_RD;
              end else begin
                issue_cnt <= issue_cnt + 6'd1;
              end
            end
          end
          ST_PAR_RD: begin
            if (read_en) state <= ST_PAR_CAP;
          end
          ST_PAR_CAP: begin
            pkt_done   <= 1'b1;
            parity_err <= (data_out != run_parity);
            state      <= ST_CHECK;
          end
          ST_CHECK: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_rx_client.sv
// tb/tb_router_rx_client.sv - scoreboard bench for router_rx_client
module tb_router_rx_client;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       soft_reset = 1'b0;
  logic       rx_ready = 1'b1;
  logic       read_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       pkt_done;
  logic       parity_err;
  logic       pkt_abort;
  logic       busy;

  router_rx_client #(
    .START_DELAY (2),
    .DATA_W      (8)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .soft_reset (soft_reset),
    .rx_ready   (rx_ready),
    .read_en    (read_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pkt_addr   (pkt_addr),
    .pkt_len    (pkt_len),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .pkt_abort  (pkt_abort),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;   // 0 good, 1 parity error, 2 abort
    int addr;
    int len;
  } status_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] fifo[$];
  logic [7:0] exp_bytes[$];
  status_t    exp_stat[$];
  logic [7:0] pl[$];
  status_t    cur_s;
  bit         rand_mode = 1'b0;
  bit         hold_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // router port: registered read data, one byte per read strobe
  always @(posedge clock) begin
    if (read_en && fifo.size() > 0) data_out <= fifo.pop_front();
  end

  // input pacing just after each active edge
  always begin
    @(posedge clock);
    #1;
    if (rand_mode) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      hold_vld = ($urandom_range(0, 4) == 0);
    end
    vld_out = (fifo.size() > 0) && !hold_vld;
  end

  // scoreboard monitor on the inactive edge
  always @(negedge clock) begin
    if (rx_valid === 1'b1) begin
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
      end else begin
        check("rx_data", rx_data, exp_bytes.pop_front());
      end
    end
    if (pkt_done === 1'b1 || pkt_abort === 1'b1) begin
      check("done_and_abort", pkt_done & pkt_abort, 0);
      if (exp_stat.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL status_unexpected: got done=%0b abort=%0b expected none", pkt_done, pkt_abort);
      end else begin
        cur_s = exp_stat.pop_front();
        check("pkt_abort", pkt_abort, cur_s.kind == 2);
        if (cur_s.kind != 2) begin
          check("parity_err", parity_err, cur_s.kind);
          check("pkt_addr", pkt_addr, cur_s.addr);
          check("pkt_len", pkt_len, cur_s.len);
        end else begin
          check("busy_on_abort", busy, 0);
        end
      end
    end
    if (parity_err === 1'b1 && pkt_done !== 1'b1) check("parity_err_without_done", pkt_done, 1);
  end

  // mode 0 correct parity, 1 explicit parity byte, 2 corrupted parity
  task automatic send_pkt(input logic [1:0] addr, input int mode, input logic [7:0] val);
    logic [7:0] acc;
    logic [7:0] par;
    acc = {6'(pl.size()), addr};
    fifo.push_back(acc);
    foreach (pl[k]) begin
      fifo.push_back(pl[k]);
      exp_bytes.push_back(pl[k]);
      acc = acc ^ pl[k];
    end
    if (mode == 0)      par = acc;
    else if (mode == 1) par = val;
    else                par = acc ^ 8'($urandom_range(1, 255));
    fifo.push_back(par);
    exp_stat.push_back('{kind: (par != acc) ? 1 : 0, addr: int'(addr), len: pl.size()});
  endtask

  // packet whose tail will be cut off: only the first nexp bytes are expected downstream
  task automatic load_cut(input logic [1:0] addr, input int nexp);
    logic [7:0] acc;
    acc = {6'(pl.size()), addr};
    fifo.push_back(acc);
    foreach (pl[k]) begin
      fifo.push_back(pl[k]);
      if (k < nexp) exp_bytes.push_back(pl[k]);
      acc = acc ^ pl[k];
    end
    fifo.push_back(acc);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_stat.size() != 0 || exp_bytes.size() != 0 || fifo.size() != 0 || busy !== 1'b0) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check(name, n < 4000, 1);
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_en"}, read_en, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_pkt_addr"}, pkt_addr, 0);
    check({tag, "_pkt_len"}, pkt_len, 0);
    check({tag, "_pkt_done"}, pkt_done, 0);
    check({tag, "_parity_err"}, parity_err, 0);
    check({tag, "_pkt_abort"}, pkt_abort, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t_hdr;
    int  t_rx;
    int  nrd;
    int  len;
    bit  v[64];
    int  edge_len[3];
    edge_len[0] = 0;
    edge_len[1] = 1;
    edge_len[2] = 63;

    tick(2);
    @(negedge clock);
    check_all_zero("reset");
    tick(1);
    resetn = 1'b1;
    tick(2);

    // good 3-byte packet with header-read to first byte latency
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd1, 0, 8'h00);
    t_hdr = -1;
    t_rx  = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (read_en === 1'b1 && t_hdr < 0) t_hdr = c;
      if (rx_valid === 1'b1 && t_rx < 0) t_rx = c;
      v[c] = rx_valid;
    end
    check("hdr_to_rx_latency", t_rx - t_hdr, 3);
    if (t_rx >= 0 && t_rx < 62) check("rx_back_to_back", {v[t_rx + 1], v[t_rx + 2]}, 2'b11);
    tick(1);
    wait_drain("drain_good");

    // same packet with a wrong parity byte
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd1, 1, 8'h00);
    wait_drain("drain_bad_parity");

    // zero-length packet
    pl.delete();
    send_pkt(2'd2, 1, 8'h02);
    wait_drain("drain_len0");

    // downstream stall after the second payload read
    pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_pkt(2'd3, 0, 8'h00);
    nrd = 0;
    for (int c = 0; c < 200 && nrd < 3; c++) begin
      @(negedge clock);
      if (read_en === 1'b1) nrd++;
    end
    check("third_read_seen", nrd, 3);
    tick(1);
    rx_ready = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("stall_read_en", read_en, 0);
    end
    tick(1);
    rx_ready = 1'b1;
    wait_drain("drain_stall");

    // soft reset while idle must not pulse
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    @(negedge clock);
    check("idle_soft_reset_busy", busy, 0);
    check("idle_soft_reset_abort", pkt_abort, 0);
    tick(1);

    // soft reset in the middle of the payload
    pl.delete();
    for (int k = 0; k < 6; k++) pl.push_back(8'($urandom));
    rx_ready = 1'b0;
    load_cut(2'd3, 2);
    exp_stat.push_back('{kind: 2, addr: 0, len: 0});
    tick(10);
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    tick(3);
    soft_reset = 1'b1;
    fifo.delete();
    tick(1);
    soft_reset = 1'b0;
    rx_ready = 1'b1;
    wait_drain("drain_abort");
    pl = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    send_pkt(2'd0, 0, 8'h00);
    wait_drain("drain_after_abort");

    // hard reset in the middle of the payload
    pl.delete();
    for (int k = 0; k < 5; k++) pl.push_back(8'($urandom));
    rx_ready = 1'b0;
    load_cut(2'd1, 2);
    tick(10);
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    tick(3);
    resetn = 1'b0;
    fifo.delete();
    @(posedge clock);
    @(negedge clock);
    check_all_zero("midreset");
    tick(1);
    resetn = 1'b1;
    rx_ready = 1'b1;
    tick(1);
    pl = '{8'h01, 8'h02};
    send_pkt(2'd2, 0, 8'h00);
    wait_drain("drain_after_reset");

    // randomized packets with random stalls on both sides
    rand_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      pl.delete();
      len = (i < 3) ? edge_len[i] : $urandom_range(0, 63);
      for (int k = 0; k < len; k++) pl.push_back(8'($urandom));
      send_pkt(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 2 : 0, 8'h00);
      if (i % 3 == 2) wait_drain("drain_random");
    end
    wait_drain("drain_final");
    rand_mode = 1'b0;
    hold_vld = 1'b0;
    rx_ready = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
